axi_sram_slave: RTL and testbench
=================================

// Module: axi_sram_slave
// PURPOSE
//  AXI3 slave responder: the memory-side end of the CPU's AXI master port (cache/transfer bridge).
//  Serves one read or one write burst at a time against a synchronous single-port SRAM.
//  Supports FIXED and INCR bursts, so both icache line refills (arlen=3) and single data accesses work.
//  Used as the bench/SoC memory model that the CPU AXI master talks to.
// PARAMETERS
//  MEM_AW   12   SRAM word-address width (depth = 2**MEM_AW words of 32 bits)
//  ID_W     4    AXI ID width
// PORTS
//  aclk       in   1       clock, all logic on rising edge
//  aresetn    in   1       asynchronous active-low reset
//  arid/araddr/arlen/arsize/arburst  in  ID_W/32/8/3/2   read address; arlock/arcache/arprot are accepted and ignored
//  arvalid    in   1       read address valid
//  arready    out  1       read address ready
//  rid        out  ID_W    equals the latched arid
//  rdata      out  32      read data
//  rresp      out  2       always 2'b00
//  rlast      out  1       final beat
//  rvalid     out  1       read data valid
//  rready     in   1       master accepts read data
//  awid/awaddr/awlen/awsize/awburst  in  ID_W/32/8/3/2   write address; awlock/awcache/awprot are ignored
//  awvalid    in   1       write address valid
//  awready    out  1       write address ready
//  wid/wdata/wstrb/wlast  in  ID_W/32/4/1   write data (wid ignored)
//  wvalid     in   1       write data valid
//  wready     out  1       write data ready
//  bid        out  ID_W    equals the latched awid
//  bresp      out  2       2'b00 OKAY or 2'b10 SLVERR
//  bvalid     out  1       write response valid
//  bready     in   1       master accepts write response
//  ram_en     out  1       SRAM access enable
//  ram_we     out  4       SRAM byte write enables
//  ram_addr   out  MEM_AW  SRAM word address
//  ram_wdata  out  32      SRAM write data
//  ram_rdata  in   32      SRAM read data, valid 1 cycle after ram_en && ram_we==0
// BEHAVIOUR
//  FSM states: INIT, IDLE, RD_ISSUE, RD_DATA, WR_DATA, WR_RESP. Async reset forces INIT and clears all counters/latches.
//  Reset outputs: arready=awready=wready=rvalid=bvalid=ram_en=0, ram_we=0, rlast=0, rresp=bresp=0.
//  INIT -> IDLE unconditionally on the first clock after aresetn rises, so the handshake readies are 0 for that cycle.
//  IDLE: arready=1; awready = !arvalid, so a read wins when AR and AW arrive in the same cycle.
//  AR handshake: latch id, word address addr[MEM_AW+1:2], len, burst; clear beat count; go to RD_ISSUE.
//  RD_ISSUE: ram_en=1, ram_we=0, ram_addr=current address; go to RD_DATA next cycle.
//  RD_DATA: rdata is registered from ram_rdata on entry and held stable while rvalid && !rready.
//    rvalid=1; rlast = (count==len).
//    On R handshake: if rlast go to IDLE, else count+1, advance address, go to RD_ISSUE (2 cycles per beat).
//  Address advance: INCR adds 1 word, wrapping modulo 2**MEM_AW. FIXED holds the address.
//    WRAP (2'b10) is treated as INCR. Size is taken as 4 bytes regardless of ax_size.
//  AW handshake: latch id, address, len, burst; clear count and err; go to WR_DATA.
//  WR_DATA: wready=1. On W handshake: ram_en=1, ram_we=wstrb, ram_wdata=wdata, ram_addr=current, all in the same cycle.
//    If wlast != (count==len), set err.
//    The burst ends strictly on count==len and then goes to WR_RESP; otherwise advance as for reads.
//  WR_RESP: bvalid=1, bid=latched id, bresp = err ? 2'b10 : 2'b00. On bready go to IDLE.
//  Only one outstanding transaction: arready=awready=0 outside IDLE.
//  No output depends combinationally on rready or bready.
//  len is a full 8 bits: bursts of 1..256 beats; count is 8 bits and never overflows because it stops at len.
//  Reset asserted mid-burst: the transaction is abandoned immediately, no further beats or B response, state is INIT.
// TESTING
//  1 Single read: araddr=0x1C0, arlen=0, arid=2; SRAM word 0x70=0xDEADBEEF
//    -> one R beat rdata=0xDEADBEEF, rid=2, rlast=1, rresp=0; rvalid 2 cycles after the AR handshake.
//  2 Line refill: araddr=0x100, arlen=3, INCR, rready toggling 1/0
//    -> words 0x40..0x43 in order; rdata stable while stalled; rlast only on the 4th beat.
//  3 Byte write: awaddr=0x8, awlen=0, wstrb=4'b0010, wdata=0x0000AB00 on a word holding 0x11223344
//    -> word becomes 0x1122AB44; bresp=0; bid=awid.
//  4 Simultaneous AR and AW valid in IDLE
//    -> AR accepted first, awready=0 until the read's last R handshake; the write then completes.
//  5 Malformed write: awlen=1 with wlast=1 on beat 0
//    -> 2 beats written, bresp=2'b10; then the next read returns OKAY.
//  6 Wrap and reset: INCR burst from the top word, arlen=1 -> second beat reads word 0.
//    Reset asserted during RD_DATA -> rvalid=0 at once; arready=1 two cycles after release.

Source files
------------

// File: rtl/axi_sram_slave.sv
// AXI3 slave that serves one read or write burst at a time from a synchronous
// single-port SRAM; FIXED and INCR bursts (WRAP treated as INCR), 32-bit beats.
module axi_sram_slave #(
  parameter int unsigned MEM_AW = 12,
  parameter int unsigned ID_W   = 4
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [ID_W-1:0]   arid,
  input  logic [31:0]       araddr,
  input  logic [7:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  input  logic [1:0]        arlock,
  input  logic [3:0]        arcache,
  input  logic [2:0]        arprot,
  input  logic              arvalid,
  output logic              arready,
  output logic [ID_W-1:0]   rid,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  input  logic [ID_W-1:0]   awid,
  input  logic [31:0]       awaddr,
  input  logic [7:0]        awlen,
  input  logic [2:0]        awsize,
  input  logic [1:0]        awburst,
  input  logic [1:0]        awlock,
  input  logic [3:0]        awcache,
  input  logic [2:0]        awprot,
  input  logic              awvalid,
  output logic              awready,
  input  logic [ID_W-1:0]   wid,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  output logic [ID_W-1:0]   bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [MEM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {INIT, IDLE, RD_ISSUE, RD_DATA, WR_DATA, WR_RESP} state_t;

  state_t            state_q, state_d;
  logic [MEM_AW-1:0] addr_q, addr_next;
  logic [7:0]        len_q, count_q;
  logic [1:0]        burst_q;
  logic [ID_W-1:0]   id_q;
  logic              err_q;
  logic [31:0]       rdata_q;
  logic              rd_first_q;
  logic              ar_hs, aw_hs, r_hs, w_hs, beat_last;

  // Sideband fields and byte-offset address bits carry no meaning for this memory.
  logic unused_ok;
  assign unused_ok = ^{arsize, arlock, arcache, arprot, awsize, awlock, awcache, awprot, wid,
                       araddr[31:MEM_AW+2], araddr[1:0], awaddr[31:MEM_AW+2], awaddr[1:0]};

  assign ar_hs     = (state_q == IDLE) && arvalid;
  assign aw_hs     = (state_q == IDLE) && awvalid && !arvalid;
  assign r_hs      = (state_q == RD_DATA) && rready;
  assign w_hs      = (state_q == WR_DATA) && wvalid;
  assign beat_last = (count_q == len_q);
  assign addr_next = (burst_q == BURST_FIXED) ? addr_q : addr_q + MEM_AW'(1);
  assign rid       = id_q;
  assign bid       = id_q;
  assign rresp     = RESP_OKAY;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= INIT;
      addr_q     <= '0;
      len_q      <= '0;
      count_q    <= '0;
      burst_q    <= '0;
      id_q       <= '0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      rd_first_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_first_q <= (state_q == RD_ISSUE);
      if (state_q == RD_DATA) rdata_q <= rdata;
      if (ar_hs) begin
        id_q    <= arid;
        addr_q  <= araddr[MEM_AW+1:2];
        len_q   <= arlen;
        burst_q <= arburst;
        count_q <= '0;
      end else if (aw_hs) begin
        id_q    <= awid;
        addr_q  <= awaddr[MEM_AW+1:2];
        len_q   <= awlen;
        burst_q <= awburst;
        count_q <= '0;
        err_q   <= 1'b0;
      end
      if ((r_hs || w_hs) && !beat_last) begin
        count_q <= count_q + 8'd1;
        addr_q  <= addr_next;
      end
      // wlast must coincide exactly with the beat count reaching len
      if (w_hs && (wlast != beat_last)) err_q <= 1'b1;
    end
  end

  // Next state and handshake/SRAM strobes; SRAM data is live on the first data cycle, held after.
  always_comb begin
    state_d   = state_q;
    arready   = 1'b0;
    awready   = 1'b0;
    wready    = 1'b0;
    rvalid    = 1'b0;
    rlast     = 1'b0;
    bvalid    = 1'b0;
    bresp     = RESP_OKAY;
    ram_en    = 1'b0;
    ram_we    = 4'b0000;
    ram_addr  = addr_q;
    ram_wdata = wdata;
    rdata     = rd_first_q ? ram_rdata : rdata_q;
    case (state_q)
      INIT: state_d = IDLE;
      IDLE: begin
        arready = 1'b1;
        awready = !arvalid;
        if (arvalid)      state_d = RD_ISSUE;
        else if (awvalid) state_d = WR_DATA;
      end
      RD_ISSUE: begin
        ram_en  = 1'b1;
        state_d = RD_DATA;
      end
      RD_DATA: begin
        rvalid = 1'b1;
        rlast  = beat_last;
        if (rready) state_d = beat_last ? IDLE : RD_ISSUE;
      end
      WR_DATA: begin
        wready = 1'b1;
        if (wvalid) begin
          ram_en = 1'b1;
          ram_we = wstrb;
          if (beat_last) state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        bvalid = 1'b1;
        bresp  = err_q ? RESP_SLVERR : RESP_OKAY;
        if (bready) state_d = IDLE;
      end
      default: state_d = INIT;
    endcase
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Scoreboarded bench for axi_sram_slave: expected beats/responses are queued as
// stimulus is issued and compared as the slave returns them. SRAM is a bench model.
module tb_axi_sram_slave;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic        stable;
  } rbeat_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } bresp_t;

  typedef struct packed {
    logic [11:0] addr;
    logic [31:0] data;
  } mword_t;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [3:0]  arid = '0, awid = '0, wid = '0, rid, bid;
  logic [31:0] araddr = '0, awaddr = '0, wdata = '0, rdata, ram_wdata, ram_rdata = '0;
  logic [7:0]  arlen = '0, awlen = '0;
  logic [2:0]  arsize = 3'd2, awsize = 3'd2, arprot = '0, awprot = '0;
  logic [1:0]  arburst = 2'b01, awburst = 2'b01, arlock = '0, awlock = '0, rresp, bresp;
  logic [3:0]  arcache = '0, awcache = '0, wstrb = '0, ram_we;
  logic        arvalid = 0, awvalid = 0, wvalid = 0, wlast = 0, rready = 0, bready = 0;
  logic        arready, awready, wready, rvalid, rlast, bvalid, ram_en;
  logic [11:0] ram_addr;

  int n_checks = 0;
  int n_fail = 0;
  int aw_seen = 0;

  rbeat_t exp_r[$], got_r[$];
  bresp_t exp_b[$];
  mword_t exp_m[$];

  logic [31:0] mem [0:4095];
  bit          init_done;
  logic        pre_en = 1'b0;
  logic [11:0] pre_addr = '0;
  logic [31:0] pre_data = '0;

  axi_sram_slave #(.MEM_AW(12), .ID_W(4)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 aclk = ~aclk;

  function automatic logic [31:0] pat(input logic [11:0] a);
    return {8'h5A, 4'h0, a, ~a[7:0]};
  endfunction

  // Synchronous single-port SRAM: read data one cycle after an enabled read.
  always @(posedge aclk) begin
    if (!init_done) begin
      for (int i = 0; i < 4096; i++) mem[i] <= pat(12'(i));
      init_done <= 1'b1;
    end else if (pre_en) begin
      mem[pre_addr] <= pre_data;
    end else if (ram_en) begin
      if (ram_we == 4'b0000) ram_rdata <= mem[ram_addr];
      else for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
  end

  task automatic poke(input logic [11:0] a, input logic [31:0] d);
    pre_addr = a; pre_data = d; pre_en = 1'b1;
    @(posedge aclk); #1;
    pre_en = 1'b0;
  endtask

  task automatic do_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                       input logic [1:0] burst, output bit ok);
    bit hs = 0;
    arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
    for (int i = 0; i < 50 && !hs; i++) begin
      #1; hs = arready;
      @(posedge aclk); #1;
    end
    arvalid = 1'b0;
    ok = hs;
  endtask

  task automatic do_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                       output bit ok);
    bit hs = 0;
    awid = id; awaddr = addr; awlen = len; awburst = 2'b01; awvalid = 1'b1;
    for (int i = 0; i < 50 && !hs; i++) begin
      #1; hs = awready;
      @(posedge aclk); #1;
    end
    awvalid = 1'b0;
    ok = hs;
  endtask

  task automatic do_w(input logic [31:0] d, input logic [3:0] s, input logic l, output bit ok);
    bit hs = 0;
    wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
    for (int i = 0; i < 50 && !hs; i++) begin
      #1; hs = wready;
      @(posedge aclk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    ok = hs;
  endtask

  task automatic collect_b(output bresp_t g, output bit ok);
    bit hs = 0;
    g = '0;
    bready = 1'b1;
    for (int i = 0; i < 50 && !hs; i++) begin
      if (bvalid) begin hs = 1; g = '{id: bid, resp: bresp}; end
      @(posedge aclk); #1;
    end
    bready = 1'b0;
    ok = hs;
  endtask

  // Gathers n R beats into got_r; stall mode accepts only every third cycle.
  task automatic collect_r(input int n, input bit stall, output bit ok);
    int got_n = 0;
    int cyc = 0;
    bit stalled = 0, stable = 1;
    logic [31:0] held = '0;
    while (got_n < n && cyc < 300) begin
      rready = stall ? (cyc % 3 == 2) : 1'b1;
      if (awready) aw_seen++;
      if (rvalid) begin
        if (stalled && rdata !== held) stable = 0;
        if (rready) begin
          got_r.push_back('{id: rid, data: rdata, resp: rresp, last: rlast, stable: stable});
          got_n++; stalled = 0; stable = 1;
        end else begin
          stalled = 1; held = rdata;
        end
      end
      @(posedge aclk); #1;
      cyc++;
    end
    rready = 1'b0;
    ok = (got_n == n);
  endtask

  task automatic test_reset;
    @(posedge aclk); @(posedge aclk); #1;
    n_checks++;
    if ({arready, awready, wready, rvalid, bvalid, ram_en, ram_we, rlast, rresp, bresp} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b required all zero",
               {arready, awready, wready, rvalid, bvalid, ram_en, ram_we, rlast, rresp, bresp});
    end
    aresetn = 1'b1;
    #1;
    n_checks++;
    if ({arready, awready} !== 2'b00) begin
      n_fail++; $display("FAIL init_readies: got %b required 00", {arready, awready});
    end
    @(posedge aclk); #1;
    n_checks++;
    if ({arready, awready} !== 2'b11) begin
      n_fail++; $display("FAIL idle_readies: got %b required 11", {arready, awready});
    end
  endtask

  task automatic test_single_read;
    bit ok;
    rbeat_t e, g;
    poke(12'h070, 32'hDEADBEEF);
    exp_r.push_back('{id: 4'd2, data: 32'hDEADBEEF, resp: 2'b00, last: 1'b1, stable: 1'b1});
    do_ar(4'd2, 32'h1C0, 8'd0, 2'b01, ok);
    n_checks++;
    if (rvalid !== 1'b0) begin n_fail++; $display("FAIL single_rvalid_early: got %b required 0", rvalid); end
    @(posedge aclk); #1;
    n_checks++;
    if (rvalid !== 1'b1) begin n_fail++; $display("FAIL single_rvalid_latency: got %b required 1", rvalid); end
    collect_r(1, 0, ok);
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL single_timeout: got %b required 1", ok); end
    while (exp_r.size() > 0) begin
      e = exp_r.pop_front(); g = '0;
      if (got_r.size() > 0) g = got_r.pop_front();
      n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL single_beat: got %h required %h", g, e); end
    end
  endtask

  task automatic test_line_refill;
    bit ok;
    rbeat_t e, g;
    for (int i = 0; i < 4; i++)
      exp_r.push_back('{id: 4'd1, data: pat(12'h040 + 12'(i)), resp: 2'b00, last: (i == 3), stable: 1'b1});
    do_ar(4'd1, 32'h100, 8'd3, 2'b01, ok);
    collect_r(4, 1, ok);
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL refill_timeout: got %b required 1", ok); end
    while (exp_r.size() > 0) begin
      e = exp_r.pop_front(); g = '0;
      if (got_r.size() > 0) g = got_r.pop_front();
      n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL refill_beat: got %h required %h", g, e); end
    end
  endtask

  task automatic test_byte_write;
    bit ok;
    bresp_t gb, eb;
    mword_t em;
    poke(12'h002, 32'h11223344);
    exp_b.push_back('{id: 4'd5, resp: 2'b00});
    exp_m.push_back('{addr: 12'h002, data: 32'h1122AB44});
    do_aw(4'd5, 32'h8, 8'd0, ok);
    do_w(32'h0000AB00, 4'b0010, 1'b1, ok);
    collect_b(gb, ok);
    eb = exp_b.pop_front();
    n_checks++;
    if (gb !== eb) begin n_fail++; $display("FAIL byte_write_b: got %h required %h", gb, eb); end
    while (exp_m.size() > 0) begin
      em = exp_m.pop_front();
      n_checks++;
      if (mem[em.addr] !== em.data) begin
        n_fail++; $display("FAIL byte_write_mem: got %h required %h", mem[em.addr], em.data);
      end
    end
  endtask

  task automatic test_simultaneous;
    bit ok;
    rbeat_t e, g;
    bresp_t gb, eb;
    mword_t em;
    exp_r.push_back('{id: 4'd3, data: pat(12'h010), resp: 2'b00, last: 1'b1, stable: 1'b1});
    exp_b.push_back('{id: 4'd9, resp: 2'b00});
    exp_m.push_back('{addr: 12'h008, data: 32'hCAFEF00D});
    arid = 4'd3; araddr = 32'h40; arlen = 8'd0; arburst = 2'b01; arvalid = 1'b1;
    awid = 4'd9; awaddr = 32'h20; awlen = 8'd0; awburst = 2'b01; awvalid = 1'b1;
    #1;
    n_checks++;
    if ({arready, awready} !== 2'b10) begin
      n_fail++; $display("FAIL collision_readies: got %b required 10", {arready, awready});
    end
    @(posedge aclk); #1;
    arvalid = 1'b0;
    aw_seen = 0;
    collect_r(1, 0, ok);
    n_checks++;
    if (aw_seen !== 0) begin n_fail++; $display("FAIL collision_awready_early: got %0d required 0", aw_seen); end
    e = exp_r.pop_front(); g = '0;
    if (got_r.size() > 0) g = got_r.pop_front();
    n_checks++;
    if (g !== e) begin n_fail++; $display("FAIL collision_read: got %h required %h", g, e); end
    do_aw(4'd9, 32'h20, 8'd0, ok);
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL collision_aw_timeout: got %b required 1", ok); end
    do_w(32'hCAFEF00D, 4'b1111, 1'b1, ok);
    collect_b(gb, ok);
    eb = exp_b.pop_front();
    n_checks++;
    if (gb !== eb) begin n_fail++; $display("FAIL collision_b: got %h required %h", gb, eb); end
    em = exp_m.pop_front();
    n_checks++;
    if (mem[em.addr] !== em.data) begin
      n_fail++; $display("FAIL collision_mem: got %h required %h", mem[em.addr], em.data);
    end
  endtask

  task automatic test_malformed_write;
    bit ok;
    rbeat_t e, g;
    bresp_t gb, eb;
    mword_t em;
    exp_b.push_back('{id: 4'd7, resp: 2'b10});
    exp_m.push_back('{addr: 12'h0C0, data: 32'h0BAD0001});
    exp_m.push_back('{addr: 12'h0C1, data: 32'h0BAD0002});
    do_aw(4'd7, 32'h300, 8'd1, ok);
    do_w(32'h0BAD0001, 4'b1111, 1'b1, ok);
    do_w(32'h0BAD0002, 4'b1111, 1'b1, ok);
    collect_b(gb, ok);
    eb = exp_b.pop_front();
    n_checks++;
    if (gb !== eb) begin n_fail++; $display("FAIL malformed_b: got %h required %h", gb, eb); end
    while (exp_m.size() > 0) begin
      em = exp_m.pop_front();
      n_checks++;
      if (mem[em.addr] !== em.data) begin
        n_fail++; $display("FAIL malformed_mem: got %h required %h", mem[em.addr], em.data);
      end
    end
    exp_r.push_back('{id: 4'd4, data: 32'h0BAD0002, resp: 2'b00, last: 1'b1, stable: 1'b1});
    do_ar(4'd4, 32'h304, 8'd0, 2'b01, ok);
    collect_r(1, 0, ok);
    e = exp_r.pop_front(); g = '0;
    if (got_r.size() > 0) g = got_r.pop_front();
    n_checks++;
    if (g !== e) begin n_fail++; $display("FAIL after_err_read: got %h required %h", g, e); end
  endtask

  task automatic test_wrap_and_reset;
    bit ok;
    int stray = 0;
    rbeat_t e, g;
    exp_r.push_back('{id: 4'd6, data: pat(12'hFFF), resp: 2'b00, last: 1'b0, stable: 1'b1});
    exp_r.push_back('{id: 4'd6, data: pat(12'h000), resp: 2'b00, last: 1'b1, stable: 1'b1});
    exp_r.push_back('{id: 4'd8, data: pat(12'h123), resp: 2'b00, last: 1'b0, stable: 1'b1});
    exp_r.push_back('{id: 4'd8, data: pat(12'h123), resp: 2'b00, last: 1'b1, stable: 1'b1});
    do_ar(4'd6, 32'h3FFC, 8'd1, 2'b01, ok);
    collect_r(2, 0, ok);
    do_ar(4'd8, 32'h48C, 8'd1, 2'b00, ok);
    collect_r(2, 1, ok);
    while (exp_r.size() > 0) begin
      e = exp_r.pop_front(); g = '0;
      if (got_r.size() > 0) g = got_r.pop_front();
      n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL wrap_fixed_beat: got %h required %h", g, e); end
    end
    do_ar(4'd2, 32'h140, 8'd3, 2'b01, ok);
    @(posedge aclk); #1;
    n_checks++;
    if (rvalid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_rvalid: got %b required 1", rvalid); end
    aresetn = 1'b0;
    #1;
    n_checks++;
    if ({rvalid, ram_en, arready} !== 3'b000) begin
      n_fail++; $display("FAIL reset_abandon: got %b required 000", {rvalid, ram_en, arready});
    end
    @(posedge aclk); @(posedge aclk); #1;
    aresetn = 1'b1;
    #1;
    n_checks++;
    if (arready !== 1'b0) begin n_fail++; $display("FAIL post_reset_init: got %b required 0", arready); end
    @(posedge aclk); #1;
    n_checks++;
    if (arready !== 1'b1) begin n_fail++; $display("FAIL post_reset_idle: got %b required 1", arready); end
    rready = 1'b1; bready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (rvalid || bvalid) stray++;
      @(posedge aclk); #1;
    end
    rready = 1'b0; bready = 1'b0;
    n_checks++;
    if (stray !== 0) begin n_fail++; $display("FAIL post_reset_stray: got %0d required 0", stray); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_read();
    test_line_refill();
    test_byte_write();
    test_simultaneous();
    test_malformed_write();
    test_wrap_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
